// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// B (load) has priority; A (ALU) wins after STARVE_LIMIT stalled cycles.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Wt_addr,
    output logic [DATA_W-1:0] Wt_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

    logic [WW-1:0] wait_a;
    logic          grant_a;
    logic          grant_b;

    always_comb begin
        grant_a = a_valid & (~b_valid | (wait_a == LIMIT));
        grant_b = b_valid & ~grant_a;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // wait_a counts consecutive cycles A was held off
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_a <= '0;
        end else if (!a_valid || grant_a) begin
            wait_a <= '0;
        end else if (wait_a != LIMIT) begin
            wait_a <= wait_a + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite <= 1'b0;
            Wt_addr  <= '0;
            Wt_data  <= '0;
        end else if (grant_a) begin
            RegWrite <= (a_addr != '0);
            Wt_addr  <= a_addr;
            Wt_data  <= a_data;
        end else if (grant_b) begin
            RegWrite <= (b_addr != '0);
            Wt_addr  <= b_addr;
            Wt_data  <= b_data;
        end else begin
            RegWrite <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (a_valid && b_valid && conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule
